// File: rtl/video_timing_gen_scaled.sv
// video_timing_gen_scaled
// Parametrised CEA-style raster timing generator with downscaled render
// coordinates. The render scale shift (0..3) is latched from scale_in only on
// the new-frame edge, so a frame is always drawn at a single scale.
//
// Optional build macro: VTG_TEST_PATTERN_EN adds tp_red/tp_green/tp_blue,
// an eight-bar colour test pattern aligned with ad_out.
//
// Every output is registered. Each output is computed from the next-state
// counters, so all outputs change together on the same edge.

module video_timing_gen_scaled #(
  parameter int   H_ACTIVE      = 1280,
  parameter int   H_FP          = 110,
  parameter int   H_SYNC        = 40,
  parameter int   H_BP          = 220,
  parameter int   V_ACTIVE      = 720,
  parameter int   V_FP          = 5,
  parameter int   V_SYNC        = 5,
  parameter int   V_BP          = 20,
  parameter bit   HS_POL        = 1'b1,
  parameter bit   VS_POL        = 1'b1,
  parameter int   FRAME_MAX     = 60,
  parameter int   DEFAULT_SCALE = 2,
  localparam int  H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW            = $clog2(H_TOTAL),
  localparam int  VW            = $clog2(V_TOTAL),
  localparam int  FW            = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1
) (
  input  logic          clk_pixel_in,
  input  logic          rst_in,
  input  logic [1:0]    scale_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out,
  output logic [FW-1:0] fc_out,
  output logic [HW-1:0] x_out,
  output logic [VW-1:0] y_out,
  output logic          pix_stb_out,
  output logic [1:0]    scale_out
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [7:0]    tp_red,
  output logic [7:0]    tp_green,
  output logic [7:0]    tp_blue
`endif
);

  localparam logic [1:0] RST_SCALE = 2'(DEFAULT_SCALE);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Low until the first edge after reset: that edge presents (0,0) instead
  // of advancing, so the raster starts at the origin with ad_out already high.
  logic running;

  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          hs_next;
  logic          vs_next;
  logic          ad_next;
  logic          nf_next;
  logic [FW-1:0] fc_next;
  logic [1:0]    s_next;
  logic [HW-1:0] x_next;
  logic [VW-1:0] y_next;
  logic [HW-1:0] h_mask;
  logic [VW-1:0] v_mask;
  logic          stb_next;

  // Next raster position, decoded syncs/flags and latched scale.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    h_next = '0;
    v_next = '0;
    if (running) begin
      if (hcount_out == HW'(H_TOTAL - 1)) begin
        h_next = '0;
        v_next = (vcount_out == VW'(V_TOTAL - 1)) ? '0 : vcount_out + VW'(1);
      end else begin
        h_next = hcount_out + HW'(1);
        v_next = vcount_out;
      end
    end

    // Range checks in 32-bit so a sync ending exactly at TOTAL cannot truncate.
    hs_next = ((int'(h_next) >= HS_START) && (int'(h_next) < HS_END)) ? HS_POL : ~HS_POL;
    vs_next = ((int'(v_next) >= VS_START) && (int'(v_next) < VS_END)) ? VS_POL : ~VS_POL;
    ad_next = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
    nf_next = (int'(h_next) == H_ACTIVE) && (int'(v_next) == V_ACTIVE);

    fc_next = fc_out;
    s_next  = scale_out;
    if (nf_next) begin
      fc_next = (int'(fc_out) == FRAME_MAX - 1) ? '0 : fc_out + FW'(1);
      s_next  = scale_in;
    end

    x_next   = h_next >> s_next;
    y_next   = v_next >> s_next;
    h_mask   = (HW'(1) << s_next) - HW'(1);
    v_mask   = (VW'(1) << s_next) - VW'(1);
    stb_next = ad_next && ((h_next & h_mask) == '0) && ((v_next & v_mask) == '0);
  end

`ifdef VTG_TEST_PATTERN_EN
  // Width of the active line in scaled pixels, one divisor per scale shift.
  localparam int unsigned D0 = ((H_ACTIVE >> 0) > 0) ? (H_ACTIVE >> 0) : 1;
  localparam int unsigned D1 = ((H_ACTIVE >> 1) > 0) ? (H_ACTIVE >> 1) : 1;
  localparam int unsigned D2 = ((H_ACTIVE >> 2) > 0) ? (H_ACTIVE >> 2) : 1;
  localparam int unsigned D3 = ((H_ACTIVE >> 3) > 0) ? (H_ACTIVE >> 3) : 1;

  logic [31:0] x8;
  logic [2:0]  bar;
  logic [7:0]  r_next;
  logic [7:0]  g_next;
  logic [7:0]  b_next;

  // Colour-bar index and level; bar order white, yellow, cyan, green,
  // magenta, red, blue, black maps to R=!bar[1], G=!bar[2], B=!bar[0].
  always_comb begin
    x8 = 32'(x_next) * 32'd8;
    case (s_next)
      2'd0:    bar = 3'(x8 / D0);
      2'd1:    bar = 3'(x8 / D1);
      2'd2:    bar = 3'(x8 / D2);
      default: bar = 3'(x8 / D3);
    endcase
    r_next = (ad_next && !bar[1]) ? 8'hFF : 8'h00;
    g_next = (ad_next && !bar[2]) ? 8'hFF : 8'h00;
    b_next = (ad_next && !bar[0]) ? 8'hFF : 8'h00;
  end
`endif

  // Output and state registers; async reset to the idle raster.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_in) begin
      running     <= 1'b0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      ad_out      <= 1'b0;
      nf_out      <= 1'b0;
      fc_out      <= '0;
      x_out       <= '0;
      y_out       <= '0;
      pix_stb_out <= 1'b0;
      scale_out   <= RST_SCALE;
`ifdef VTG_TEST_PATTERN_EN
      tp_red      <= '0;
      tp_green    <= '0;
      tp_blue     <= '0;
`endif
    end else begin
      running     <= 1'b1;
      hcount_out  <= h_next;
      vcount_out  <= v_next;
      hs_out      <= hs_next;
      vs_out      <= vs_next;
      ad_out      <= ad_next;
      nf_out      <= nf_next;
      fc_out      <= fc_next;
      x_out       <= x_next;
      y_out       <= y_next;
      pix_stb_out <= stb_next;
      scale_out   <= s_next;
`ifdef VTG_TEST_PATTERN_EN
      tp_red      <= r_next;
      tp_green    <= g_next;
      tp_blue     <= b_next;
`endif
    end
  end

endmodule

// File: doc/video_timing_gen_scaled.md
Name: video_timing_gen_scaled

Overview:
Parametrised successor to the fixed 720p timing generator. Produces raster counters, syncs, active-draw, new-frame and frame-count for any CEA-style timing. Also produces downscaled render coordinates with a runtime-selectable power-of-two scale factor, replacing the ad-hoc "hcount>>2" shifts in top_level. Sits between the pixel clock domain and the renderer/TMDS encoders.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (cycles)
H_SYNC, 40, horizontal sync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width
V_BP, 20, vertical back porch
HS_POL, 1, hs_out level while in sync (1 = active-high)
VS_POL, 1, vs_out level while in sync
FRAME_MAX, 60, frame counter modulus
DEFAULT_SCALE, 2, scale shift applied out of reset (0..3)

Ports:
clk_pixel_in  in  1  pixel clock
rst_in  in  1  asynchronous active-high reset
scale_in  in  2  requested scale shift; 0 = 1:1, 3 = 8:1
hcount_out  out  $clog2(H_TOTAL)  horizontal position
vcount_out  out  $clog2(V_TOTAL)  vertical position
hs_out  out  1  horizontal sync
vs_out  out  1  vertical sync
ad_out  out  1  active draw
nf_out  out  1  one-cycle new-frame pulse
fc_out  out  $clog2(FRAME_MAX)  frame counter
x_out  out  width of hcount_out  hcount_out >> active scale
y_out  out  width of vcount_out  vcount_out >> active scale
pix_stb_out  out  1  first native pixel of a scaled pixel, active region only
scale_out  out  2  scale shift currently in effect

Behaviour:
- One clock. Reset is asynchronous and active-high. All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset values: every output is 0, except scale_out, which resets to DEFAULT_SCALE. hs_out and vs_out reset to their inactive level (!HS_POL, !VS_POL).
- First rising edge after reset release presents position (0,0) with ad_out=1. Each later edge advances hcount by 1.
- At hcount=H_TOTAL-1, hcount wraps to 0 and vcount increments. At vcount=V_TOTAL-1 with that same wrap, vcount wraps to 0.
- hs_out = HS_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; otherwise !HS_POL. vs_out uses the same rule on vcount.
- ad_out = 1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
- nf_out = 1 for exactly one cycle, when hcount==H_ACTIVE and vcount==V_ACTIVE (first blanking pixel after the last active line).
- fc_out increments in the same cycle nf_out is asserted and wraps FRAME_MAX-1 -> 0.
- Scale latch:
  - scale_in is sampled only on the edge that asserts nf_out; scale_out takes the new value in that same cycle.
  - A change of scale_in mid-frame has no effect until the next nf_out.
  - All four values are legal.
- x_out/y_out: computed from the next-state counters and scale, so they align cycle-exactly with hcount_out/vcount_out. During blanking they continue to track the shifted counters; consumers must gate with ad_out.
- pix_stb_out = ad_out AND (low scale_out bits of hcount_out == 0) AND (low scale_out bits of vcount_out == 0). With scale 0 it equals ad_out.
- Reset mid-line: all counters return to 0 immediately (async). fc_out resets to 0.
- Counters never exceed TOTAL-1. No illegal states exist.

Optional Feature:
Macro VTG_TEST_PATTERN_EN.
- Defined: adds outputs tp_red, tp_green, tp_blue (8 bits each, registered, aligned with ad_out).
  - Eight vertical colour bars across x_out. Bar index = (x_out*8)/(H_ACTIVE>>scale_out), using the standard white/yellow/cyan/green/magenta/red/blue/black order at 8'hFF/8'h00 levels.
  - Outputs are 0 when ad_out=0.
- Undefined: ports absent, no logic generated.

Test Plan:
- Small params (H 8/2/2/4, V 4/1/1/2, FRAME_MAX 3): release reset -> hcount 0..15 repeats, vcount 0..7; hs high at hcount 10..11; vs high at vcount 5; ad high for hcount<8 and vcount<4.
- Same params -> nf_out one cycle at (8,4); fc_out sequence 1,2,0,1 over four frames.
- scale_in 0->3 mid-frame -> scale_out stays at DEFAULT_SCALE until the nf_out cycle, then becomes 3. Next frame: x_out=hcount>>3, and pix_stb_out fires only at hcount%8==0 and vcount%8==0.
- Default 720p, HS_POL=VS_POL=0 -> H period 1650, V period 750 lines. hs_out low exactly 40 cycles starting at hcount 1390. Frame length 1,237,500 cycles.
- Async reset pulse (no clock edge) at hcount 500 -> all outputs 0 immediately and scale_out=DEFAULT_SCALE. First edge after release presents (0,0) with ad_out=1.
- VTG_TEST_PATTERN_EN, scale 0, 720p -> tp = FFFFFF at x 0..159, FFFF00 at 160..319, 000000 at 1120..1279, 0 during blanking.
